bus_arbiter: RTL and testbench



---
 rtl/bus_arb_pkg.sv | 17 +
 rtl/bus_arbiter_if.sv | 31 +++
 rtl/bus_rr_pick.sv | 37 +++
 rtl/bus_arbiter.sv | 116 +++++++++++
 tb/tb_bus_arbiter.sv | 172 +++++++++++++++++
 5 files changed

// File: rtl/bus_arb_pkg.sv
// Shared types and helpers for the registered bus arbiter.
// Pure package: no logic, no latency, no backpressure.
package bus_arb_pkg;

  localparam int STAT_W = 8;

  // An index into n items needs at least one bit, even when n <= 2.
  function automatic int idx_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  typedef enum logic {
    ARB_FIXED = 1'b0,
    ARB_RR    = 1'b1
  } arb_mode_e;

endpackage

// File: rtl/bus_arbiter_if.sv
// Source-side and sink-side signals of the bus arbiter. The source side drives requests and data.
// The arbiter side returns the registered grant, bus value and statistics; there is no backpressure.
interface bus_arbiter_if
  import bus_arb_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int N_SRC = 32
);

  logic [N_SRC*WIDTH-1:0] src_data;
  logic [N_SRC-1:0]       src_req;
  logic [N_SRC-1:0]       src_lock;
  logic                   rr_mode;
  logic                   stat_clr;
  logic [N_SRC-1:0]       grant;
  logic [WIDTH-1:0]       bus_out;
  logic                   bus_valid;
  logic                   contention;
  logic [STAT_W-1:0]      contention_cnt;

  modport master (
    output src_data, src_req, src_lock, rr_mode, stat_clr,
    input  grant, bus_out, bus_valid, contention, contention_cnt
  );

  modport slave (
    input  src_data, src_req, src_lock, rr_mode, stat_clr,
    output grant, bus_out, bus_valid, contention, contention_cnt
  );

endinterface

// File: rtl/bus_rr_pick.sv
// Combinational masked priority picker: first request at or after i_start (wrapping), skipping i_excl.
// Zero latency; no backpressure.
module bus_rr_pick #(
  parameter int N  = 32,
  parameter int IW = 5
) (
  input  logic [N-1:0]  i_req,
  input  logic [IW-1:0] i_start,
  input  logic [N-1:0]  i_excl,
  output logic [N-1:0]  o_onehot,
  output logic [IW-1:0] o_idx,
  output logic          o_any
);

  logic [N-1:0] w_req;
  int           w_pos;

  always_comb begin
    o_onehot = '0;
    o_idx    = '0;
    o_any    = 1'b0;
    w_pos    = 0;
    w_req    = i_req & ~i_excl;
    for (int i = 0; i < N; i++) begin
      w_pos = int'(i_start) + i;
      if (w_pos >= N) begin
        w_pos = w_pos - N;
      end
      if (!o_any && w_req[w_pos]) begin
        o_any           = 1'b1;
        o_onehot[w_pos] = 1'b1;
        o_idx           = IW'(w_pos);
      end
    end
  end

endmodule

// File: rtl/bus_arbiter.sv
// Registered N_SRC-way bus arbiter (fixed/round-robin, lockable, optional stats via BUS_ARB_STATS_EN).
// One cycle request-to-bus latency; no backpressure, losers simply keep requesting.
module bus_arbiter
  import bus_arb_pkg::*;
#(
  parameter int WIDTH    = 32,
  parameter int N_SRC    = 32,
  parameter int LOCK_MAX = 16
) (
  input  logic          clk,
  input  logic          clr_n,
  bus_arbiter_if.slave  bif
);

  localparam int              IW   = idx_w(N_SRC);
  localparam int              LW   = $clog2(LOCK_MAX + 1);
  localparam logic [IW-1:0]   LAST = IW'(N_SRC - 1);
  localparam logic [LW-1:0]   LMAX = LW'(LOCK_MAX);

  logic [N_SRC-1:0] r_grant;
  logic [WIDTH-1:0] r_bus;
  logic [IW-1:0]    r_ptr;
  logic [LW-1:0]    r_lock_cnt;

  logic             w_busy;
  logic             w_locked;
  logic             w_hold;
  logic             w_others;
  logic [N_SRC-1:0] w_excl;
  logic [IW-1:0]    w_start;
  logic [N_SRC-1:0] w_win_onehot;
  logic [IW-1:0]    w_win_idx;
  logic             w_win_any;
  logic [WIDTH-1:0] w_win_data;
  logic [WIDTH-1:0] w_own_data;

  // While a grant is live, r_ptr is the owner's index.
  assign w_busy     = |r_grant;
  assign w_locked   = w_busy && bif.src_req[r_ptr] && bif.src_lock[r_ptr];
  assign w_hold     = w_locked && (r_lock_cnt < LMAX);
  assign w_others   = |(bif.src_req & ~r_grant);
  assign w_excl     = (w_locked && !w_hold && w_others) ? r_grant : '0;
  assign w_start    = (arb_mode_e'(bif.rr_mode) == ARB_RR) ?
                      ((r_ptr == LAST) ? '0 : r_ptr + 1'b1) : '0;
  assign w_own_data = bif.src_data[int'(r_ptr)*WIDTH +: WIDTH];
  assign w_win_data = bif.src_data[int'(w_win_idx)*WIDTH +: WIDTH];

  bus_rr_pick #(
    .N  (N_SRC),
    .IW (IW)
  ) u_pick (
    .i_req    (bif.src_req),
    .i_start  (w_start),
    .i_excl   (w_excl),
    .o_onehot (w_win_onehot),
    .o_idx    (w_win_idx),
    .o_any    (w_win_any)
  );

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      r_grant    <= '0;
      r_bus      <= '0;
      r_ptr      <= LAST;
      r_lock_cnt <= '0;
    end else if (w_hold) begin
      r_bus      <= w_own_data;
      r_lock_cnt <= r_lock_cnt + 1'b1;
    end else if (w_win_any) begin
      r_grant    <= w_win_onehot;
      r_bus      <= w_win_data;
      r_ptr      <= w_win_idx;
      r_lock_cnt <= '0;
    end else begin
      r_grant    <= '0;
      r_lock_cnt <= '0;
    end
  end

  assign bif.grant     = r_grant;
  assign bif.bus_out   = r_bus;
  assign bif.bus_valid = w_busy;

`ifdef BUS_ARB_STATS_EN
  logic              r_cont;
  logic [STAT_W-1:0] r_cont_cnt;
  logic              w_multi;

  assign w_multi = ($countones(bif.src_req) > 1);

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      r_cont     <= 1'b0;
      r_cont_cnt <= '0;
    end else if (bif.stat_clr) begin
      r_cont     <= 1'b0;
      r_cont_cnt <= '0;
    end else if (w_multi) begin
      r_cont <= 1'b1;
      if (r_cont_cnt != '1) begin
        r_cont_cnt <= r_cont_cnt + 1'b1;
      end
    end
  end

  assign bif.contention     = r_cont;
  assign bif.contention_cnt = r_cont_cnt;
`else
  logic w_unused_stat_clr;

  assign w_unused_stat_clr  = bif.stat_clr;
  assign bif.contention     = 1'b0;
  assign bif.contention_cnt = '0;
`endif

endmodule

// File: tb/tb_bus_arbiter.sv
// Directed self-checking bench for bus_arbiter (N_SRC=32, WIDTH=32, LOCK_MAX=4).
// Stats checks follow BUS_ARB_STATS_EN.
module tb_bus_arbiter;
  import bus_arb_pkg::*;

  localparam int W = 32;
  localparam int N = 32;

  logic clk = 1'b0;
  logic clr_n;
  int   n_cmp = 0;
  int   n_err = 0;

  bus_arbiter_if #(.WIDTH(W), .N_SRC(N)) bif ();

  bus_arbiter #(.WIDTH(W), .N_SRC(N), .LOCK_MAX(4)) dut (
    .clk   (clk),
    .clr_n (clr_n),
    .bif   (bif)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_data(input int i, input logic [W-1:0] v);
    bif.src_data[i*W +: W] = v;
  endtask

  task automatic test_reset();
    clr_n = 1'b1;
    bif.src_req = '0; bif.src_lock = '0; bif.rr_mode = 1'b0; bif.stat_clr = 1'b0;
    for (int i = 0; i < N; i++) set_data(i, 32'hDEAD_0000 | 32'(i));
    #2 clr_n = 1'b0;
    #1;
    n_cmp++; if (bif.grant !== 32'h0) begin n_err++; $display("FAIL rst_grant got %h want %h", bif.grant, 32'h0); end
    n_cmp++; if (bif.bus_out !== 32'h0) begin n_err++; $display("FAIL rst_bus got %h want %h", bif.bus_out, 32'h0); end
    n_cmp++; if (bif.bus_valid !== 1'b0) begin n_err++; $display("FAIL rst_valid got %b want 0", bif.bus_valid); end
    n_cmp++; if (bif.contention !== 1'b0 || bif.contention_cnt !== 8'd0) begin n_err++; $display("FAIL rst_stats got %b/%0d want 0/0", bif.contention, bif.contention_cnt); end
    #3 clr_n = 1'b1;
    // Mid-stream reset with a live grant and contention.
    bif.src_req = (32'h1 << 5) | (32'h1 << 6);
    bif.src_lock = 32'h1 << 5;
    tick();
    n_cmp++; if (bif.grant !== 32'h0000_0020 || bif.bus_out !== 32'hDEAD_0005) begin n_err++; $display("FAIL pre_rst got %h/%h want 00000020/dead0005", bif.grant, bif.bus_out); end
    #2 clr_n = 1'b0;
    #1;
    n_cmp++; if (bif.grant !== 32'h0 || bif.bus_out !== 32'h0 || bif.bus_valid !== 1'b0) begin n_err++; $display("FAIL mid_rst got %h/%h/%b want 0/0/0", bif.grant, bif.bus_out, bif.bus_valid); end
    n_cmp++; if (bif.contention !== 1'b0 || bif.contention_cnt !== 8'd0) begin n_err++; $display("FAIL mid_rst_stats got %b/%0d want 0/0", bif.contention, bif.contention_cnt); end
    bif.src_req = '0; bif.src_lock = '0;
    #2 clr_n = 1'b1;
    tick();
    n_cmp++; if (bif.grant !== 32'h0 || bif.bus_valid !== 1'b0 || bif.bus_out !== 32'h0) begin n_err++; $display("FAIL idle_after_rst got %h/%b/%h want 0/0/0", bif.grant, bif.bus_valid, bif.bus_out); end
  endtask

  task automatic test_fixed();
    bif.rr_mode = 1'b0;
    bif.src_req = (32'h1 << 3) | (32'h1 << 5) | (32'h1 << 20);
    for (int c = 0; c < 3; c++) begin
      tick();
      n_cmp++; if (bif.grant !== 32'h0000_0008 || bif.bus_out !== 32'hDEAD_0003 || bif.bus_valid !== 1'b1) begin n_err++; $display("FAIL fixed_c%0d got %h/%h/%b want 00000008/dead0003/1", c, bif.grant, bif.bus_out, bif.bus_valid); end
    end
    bif.src_req = (32'h1 << 5) | (32'h1 << 20);
    tick();
    n_cmp++; if (bif.grant !== 32'h0000_0020 || bif.bus_out !== 32'hDEAD_0005) begin n_err++; $display("FAIL fixed_next got %h/%h want 00000020/dead0005", bif.grant, bif.bus_out); end
    bif.src_req = '0;
    tick();
    n_cmp++; if (bif.grant !== 32'h0 || bif.bus_valid !== 1'b0 || bif.bus_out !== 32'hDEAD_0005) begin n_err++; $display("FAIL idle_hold got %h/%b/%h want 0/0/dead0005", bif.grant, bif.bus_valid, bif.bus_out); end
  endtask

  task automatic test_round_robin();
    logic [1:0] exp_seq [6];
    exp_seq[0] = 2'd0; exp_seq[1] = 2'd1; exp_seq[2] = 2'd2;
    exp_seq[3] = 2'd0; exp_seq[4] = 2'd1; exp_seq[5] = 2'd2;
    bif.rr_mode = 1'b1;
    bif.src_req = 32'h0000_0007;
    for (int c = 0; c < 6; c++) begin
      tick();
      n_cmp++; if (bif.grant !== (32'h1 << exp_seq[c]) || bif.bus_out !== (32'hDEAD_0000 | 32'(exp_seq[c]))) begin n_err++; $display("FAIL rr_c%0d got %h/%h want src %0d", c, bif.grant, bif.bus_out, exp_seq[c]); end
    end
    // Fixed grants source 0 and loads the pointer; round-robin then resumes at 1.
    bif.rr_mode = 1'b0;
    tick();
    n_cmp++; if (bif.grant !== 32'h0000_0001) begin n_err++; $display("FAIL mode_fixed got %h want 00000001", bif.grant); end
    bif.rr_mode = 1'b1;
    tick();
    n_cmp++; if (bif.grant !== 32'h0000_0002) begin n_err++; $display("FAIL mode_rr got %h want 00000002", bif.grant); end
    bif.src_req = '0;
    tick();
  endtask

  task automatic test_lock_timeout();
    bif.rr_mode = 1'b0;
    bif.src_req = (32'h1 << 2) | (32'h1 << 7);
    bif.src_lock = 32'h1 << 2;
    for (int c = 0; c < 5; c++) begin
      set_data(2, 32'hA000_0000 + 32'(c));
      tick();
      n_cmp++; if (bif.grant !== 32'h0000_0004 || bif.bus_out !== (32'hA000_0000 + 32'(c))) begin n_err++; $display("FAIL lock_c%0d got %h/%h want 00000004/%h", c, bif.grant, bif.bus_out, 32'hA000_0000 + 32'(c)); end
    end
    tick();
    n_cmp++; if (bif.grant !== 32'h0000_0080 || bif.bus_out !== 32'hDEAD_0007) begin n_err++; $display("FAIL lock_expire got %h/%h want 00000080/dead0007", bif.grant, bif.bus_out); end
    // Sole locked requester: the expiring edge re-grants and restarts the count.
    bif.src_req = 32'h1 << 2;
    for (int c = 0; c < 6; c++) begin
      tick();
      n_cmp++; if (bif.grant !== 32'h0000_0004) begin n_err++; $display("FAIL sole_c%0d got %h want 00000004", c, bif.grant); end
    end
    bif.src_req = (32'h1 << 2) | (32'h1 << 7);
    tick();
    n_cmp++; if (bif.grant !== 32'h0000_0004) begin n_err++; $display("FAIL lock_restart got %h want 00000004", bif.grant); end
  endtask

  task automatic test_release();
    // Dropping only the lock re-arbitrates; fixed priority picks 2 again.
    bif.src_lock = '0;
    tick();
    n_cmp++; if (bif.grant !== 32'h0000_0004) begin n_err++; $display("FAIL unlock_rewin got %h want 00000004", bif.grant); end
    bif.src_lock = 32'h1 << 2;
    bif.src_req = 32'h1 << 7;
    tick();
    n_cmp++; if (bif.grant !== 32'h0000_0080 || bif.bus_out !== 32'hDEAD_0007) begin n_err++; $display("FAIL release_move got %h/%h want 00000080/dead0007", bif.grant, bif.bus_out); end
    bif.src_req = '0;
    bif.src_lock = '0;
    tick();
    n_cmp++; if (bif.grant !== 32'h0 || bif.bus_valid !== 1'b0 || bif.bus_out !== 32'hDEAD_0007) begin n_err++; $display("FAIL release_idle got %h/%b/%h want 0/0/dead0007", bif.grant, bif.bus_valid, bif.bus_out); end
  endtask

  task automatic test_stats();
    bif.stat_clr = 1'b1;
    bif.src_req = '0;
    tick();
    bif.stat_clr = 1'b0;
    bif.src_req = 32'h0000_0003;
`ifdef BUS_ARB_STATS_EN
    n_cmp++; if (bif.contention !== 1'b0 || bif.contention_cnt !== 8'd0) begin n_err++; $display("FAIL stat_clr0 got %b/%0d want 0/0", bif.contention, bif.contention_cnt); end
    repeat (10) tick();
    n_cmp++; if (bif.contention !== 1'b1 || bif.contention_cnt !== 8'd10) begin n_err++; $display("FAIL stat_10 got %b/%0d want 1/10", bif.contention, bif.contention_cnt); end
    repeat (290) tick();
    n_cmp++; if (bif.contention !== 1'b1 || bif.contention_cnt !== 8'd255) begin n_err++; $display("FAIL stat_sat got %b/%0d want 1/255", bif.contention, bif.contention_cnt); end
    bif.stat_clr = 1'b1;
    tick();
    n_cmp++; if (bif.contention !== 1'b0 || bif.contention_cnt !== 8'd0) begin n_err++; $display("FAIL stat_clr_win got %b/%0d want 0/0", bif.contention, bif.contention_cnt); end
    bif.stat_clr = 1'b0;
    tick();
    n_cmp++; if (bif.contention !== 1'b1 || bif.contention_cnt !== 8'd1) begin n_err++; $display("FAIL stat_after_clr got %b/%0d want 1/1", bif.contention, bif.contention_cnt); end
    bif.src_req = 32'h0000_0001;
    repeat (3) tick();
    n_cmp++; if (bif.contention !== 1'b1 || bif.contention_cnt !== 8'd1) begin n_err++; $display("FAIL stat_single got %b/%0d want 1/1", bif.contention, bif.contention_cnt); end
`else
    repeat (20) tick();
    n_cmp++; if (bif.contention !== 1'b0 || bif.contention_cnt !== 8'd0) begin n_err++; $display("FAIL stat_off got %b/%0d want 0/0", bif.contention, bif.contention_cnt); end
`endif
    bif.src_req = '0;
    tick();
  endtask

  initial begin
    test_reset();
    test_fixed();
    test_round_robin();
    test_lock_timeout();
    test_release();
    test_stats();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
